// File: rtl/mesh_pkg.sv
// Shared types and defaults for the systolic mesh operand feeder.
package mesh_pkg;

    localparam int DEF_W    = 8;
    localparam int DEF_N    = 4;
    localparam int DEF_KMAX = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_FLUSH,
        ST_DRAIN,
        ST_WAIT
    } feeder_state_t;

    // LSB position of a lane inside a packed N*W operand bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/mesh_feeder_skew_line.sv
// Per-lane DEPTH-stage data+valid delay line that skews one operand lane into the mesh.
module skew_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    input  logic         vld_i,
    output logic [W-1:0] d_o,
    output logic         vld_o
);

    logic [W-1:0]     data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
                vld_q[s]  <= 1'b0;
            end
        end else begin
            data_q[0] <= d_i;
            vld_q[0]  <= vld_i;
            for (int s = 1; s < DEPTH; s++) begin
                data_q[s] <= data_q[s-1];
                vld_q[s]  <= vld_q[s-1];
            end
        end
    end

    assign d_o   = data_q[DEPTH-1];
    assign vld_o = vld_q[DEPTH-1];

endmodule

// File: rtl/mesh_feeder.sv
// Feeds skewed A columns / B rows into an N x N output-stationary mesh and sequences clear/drain.
// Optional FEEDER_STALL_CNT_EN adds a 16-bit count of starved STREAM cycles.
module mesh_feeder
    import mesh_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int N        = DEF_N,
    parameter int KMAX     = DEF_KMAX,
    parameter int PIPE_MUL = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [$clog2(KMAX+1)-1:0] cfg_k,
    output logic                      busy,
    output logic                      done,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*W-1:0]            in_a,
    input  logic [N*W-1:0]            in_b,
    output logic [N*W-1:0]            a_row,
    output logic [N-1:0]              a_row_valid,
    output logic [N*W-1:0]            b_col,
    output logic [N-1:0]              b_col_valid,
    output logic                      acc_clear_block,
    output logic                      drain
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int KW        = $clog2(KMAX + 1);
    localparam int FLUSH_CYC = N - 1 + PIPE_MUL;
    localparam int WAIT_CYC  = 2 * (N - 1) + 1;
    localparam int CW        = $clog2(WAIT_CYC + FLUSH_CYC + 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_CYC - 1);

    feeder_state_t   state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [KW-1:0]   xfer_cnt_q, xfer_cnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N*W-1:0]  a0_q, a0_d, b0_q, b0_d;
    logic            v0_q, v0_d;
    logic            xfer;

    function automatic logic [KW-1:0] sat_k(input logic [KW-1:0] k);
        if (k == '0)
            return KW'(1);
        if (k > KW'(KMAX))
            return KW'(KMAX);
        return k;
    endfunction

    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // STREAM holds one cycle past the K-th transfer so its strobe clears the
    // lane-0 register before FLUSH starts counting the N-1 skew cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = ST_STREAM;
            ST_STREAM: if (xfer_cnt_q == k_q) state_d = ST_FLUSH;
            ST_FLUSH:  if (cnt_q == FLUSH_LAST) state_d = ST_DRAIN;
            ST_DRAIN:  state_d = ST_WAIT;
            ST_WAIT:   if (cnt_q == WAIT_LAST) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready        = (state_q == ST_STREAM) && (xfer_cnt_q < k_q);
        acc_clear_block = (state_q == ST_CLEAR);
        drain           = (state_q == ST_DRAIN);
        done            = (state_q == ST_WAIT) && (cnt_q == WAIT_LAST);
        busy            = (state_q != ST_IDLE) && !done;
    end

    always_comb begin
        k_d        = k_q;
        xfer_cnt_d = xfer_cnt_q;
        if (state_q == ST_IDLE && start)
            k_d = sat_k(cfg_k);
        if (state_q == ST_CLEAR)
            xfer_cnt_d = '0;
        else if (xfer)
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        if (state_d != state_q || state_q == ST_IDLE)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;
        a0_d = xfer ? in_a : '0;
        b0_d = xfer ? in_b : '0;
        v0_d = xfer;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            xfer_cnt_q <= '0;
            cnt_q      <= '0;
            a0_q       <= '0;
            b0_q       <= '0;
            v0_q       <= 1'b0;
        end else begin
            k_q        <= k_d;
            xfer_cnt_q <= xfer_cnt_d;
            cnt_q      <= cnt_d;
            a0_q       <= a0_d;
            b0_q       <= b0_d;
            v0_q       <= v0_d;
        end
    end

    // Lane i rides the shared stage-0 register plus i further stages.
    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign a_row[lane_lsb(0, W) +: W] = a0_q[lane_lsb(0, W) +: W];
            assign b_col[lane_lsb(0, W) +: W] = b0_q[lane_lsb(0, W) +: W];
            assign a_row_valid[0]             = v0_q;
            assign b_col_valid[0]             = v0_q;
        end else begin : g_skew
            skew_line #(.W(W), .DEPTH(i)) u_a (
                .clk   (clk),
                .rst_n (rst_n),
                .d_i   (a0_q[lane_lsb(i, W) +: W]),
                .vld_i (v0_q),
                .d_o   (a_row[lane_lsb(i, W) +: W]),
                .vld_o (a_row_valid[i])
            );
            skew_line #(.W(W), .DEPTH(i)) u_b (
                .clk   (clk),
                .rst_n (rst_n),
                .d_i   (b0_q[lane_lsb(i, W) +: W]),
                .vld_i (v0_q),
                .d_o   (b_col[lane_lsb(i, W) +: W]),
                .vld_o (b_col_valid[i])
            );
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_CLEAR)
            stall_d = '0;
        else if (in_ready && !in_valid && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule
